// File: rtl/picorv32_mem_bridge.sv
// Native memory-interface slave for the RV32 core: decodes each request to on-chip RAM
// (with wait states), two MMIO registers (GPIO, cycle counter) or an error response.
module picorv32_mem_bridge #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mem_valid,
  input  logic                  mem_instr,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  output logic [31:0]           gpio_out,
  output logic                  bus_err
);

  localparam logic [31:0] GPIO_ADDR = 32'h1000_0000;
  localparam logic [31:0] CNT_ADDR  = 32'h1000_0004;
  localparam logic [3:0]  WS        = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  wcnt;
  logic        first;
  logic        is_wr;
  logic [31:0] hold;
  logic [31:0] cyc_cnt;

  logic [31:0] word_addr;
  logic        ram_hit, gpio_hit, cnt_hit, accept;

  // Fetches from the MMIO block are decoded as errors.
  assign word_addr = {mem_addr[31:2], 2'b00};
  assign ram_hit   = (mem_addr >> (ADDR_WIDTH + 2)) == 32'd0;
  assign gpio_hit  = (word_addr == GPIO_ADDR) && !mem_instr;
  assign cnt_hit   = (word_addr == CNT_ADDR)  && !mem_instr;
  assign accept    = (state == S_IDLE) && mem_valid;

  // RAM strobes only in the accept cycle so a held mem_valid never re-accesses RAM.
  assign ram_en    = resetn && accept && ram_hit;
  assign ram_we    = ram_en ? mem_wstrb : 4'b0000;
  assign ram_addr  = mem_addr[ADDR_WIDTH+1:2];
  assign ram_wdata = mem_wdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      wcnt      <= 4'd0;
      first     <= 1'b0;
      is_wr     <= 1'b0;
      hold      <= 32'd0;
      cyc_cnt   <= 32'd0;
      mem_ready <= 1'b0;
      mem_rdata <= 32'd0;
      gpio_out  <= 32'd0;
      bus_err   <= 1'b0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      case (state)
        S_IDLE: begin
          mem_ready <= 1'b0;
          mem_rdata <= 32'd0;
          if (mem_valid) begin
            if (ram_hit) begin
              state <= S_WAIT;
              wcnt  <= WS;
              first <= 1'b1;
              is_wr <= |mem_wstrb;
            end else begin
              state     <= S_RESP;
              mem_ready <= 1'b1;
              if (gpio_hit) begin
                mem_rdata <= (|mem_wstrb) ? 32'd0 : gpio_out;
                for (int k = 0; k < 4; k++)
                  if (mem_wstrb[k]) gpio_out[8*k +: 8] <= mem_wdata[8*k +: 8];
              end else if (cnt_hit) begin
                mem_rdata <= (|mem_wstrb) ? 32'd0 : cyc_cnt;
              end else begin
                mem_rdata <= 32'd0;
                bus_err   <= 1'b1;
              end
            end
          end
        end
        S_WAIT: begin
          // RAM data is only valid in the first WAIT cycle; later cycles use the held copy.
          first <= 1'b0;
          if (first) hold <= ram_rdata;
          if (wcnt == 4'd0) begin
            state     <= S_RESP;
            mem_ready <= 1'b1;
            mem_rdata <= is_wr ? 32'd0 : (first ? ram_rdata : hold);
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        default: begin
          state     <= S_IDLE;
          mem_ready <= 1'b0;
          mem_rdata <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_picorv32_mem_bridge.sv
// Directed bench for picorv32_mem_bridge: one bridge with 0 wait states, one with 1,
// each backed by a behavioural synchronous RAM; a queue holds expected responses.
module tb_picorv32_mem_bridge;

  logic                clk = 1'b0;
  logic                resetn;
  logic [1:0]          mem_valid;
  logic                mem_instr;
  logic [31:0]         mem_addr, mem_wdata;
  logic [3:0]          mem_wstrb;
  logic [1:0]          mem_ready, ram_en, bus_err;
  logic [1:0][31:0]    mem_rdata, ram_wdata, gpio_out;
  logic [1:0][3:0]     ram_we;
  logic [1:0][9:0]     ram_addr;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] rdata;
    bit          chk;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] ram [1024];
    logic [31:0] rd;

    always @(posedge clk) begin
      if (ram_en[g]) begin
        for (int k = 0; k < 4; k++)
          if (ram_we[g][k]) ram[ram_addr[g]][8*k +: 8] <= ram_wdata[g][8*k +: 8];
        rd <= ram[ram_addr[g]];
      end
    end

    picorv32_mem_bridge #(.ADDR_WIDTH(10), .WAIT_STATES(g)) u_dut (
      .clk       (clk),
      .resetn    (resetn),
      .mem_valid (mem_valid[g]),
      .mem_instr (mem_instr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_ready (mem_ready[g]),
      .mem_rdata (mem_rdata[g]),
      .ram_en    (ram_en[g]),
      .ram_we    (ram_we[g]),
      .ram_addr  (ram_addr[g]),
      .ram_wdata (ram_wdata[g]),
      .ram_rdata (rd),
      .gpio_out  (gpio_out[g]),
      .bus_err   (bus_err[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one request, returns at the negedge after the response.
  task automatic xfer(input int sel, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic instr, input bit ram,
                      input logic [31:0] exp, input bit chk, input int exp_lat,
                      output logic [31:0] got);
    exp_t e;
    int   lat;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = strb;
    mem_instr = instr;
    mem_valid[sel] = 1'b1;
    sb.push_back('{rdata: exp, chk: chk, lat: exp_lat});
    #1;
    check("ram_en_T", 32'(ram_en[sel]), 32'(ram));
    if (ram) begin
      check("ram_we_T",   32'(ram_we[sel]),   32'(strb));
      check("ram_addr_T", 32'(ram_addr[sel]), 32'(addr[11:2]));
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("ram_en_once", 32'(ram_en[sel]), 32'd0);
    end while (!mem_ready[sel] && lat < 40);
    mem_valid[sel] = 1'b0;
    e = sb.pop_front();
    check("latency", 32'(lat), 32'(e.lat));
    if (e.chk) check("rdata", mem_rdata[sel], e.rdata);
    got = mem_rdata[sel];
    @(negedge clk);
    check("ready_drop", 32'(mem_ready[sel]), 32'd0);
    check("rdata_idle", mem_rdata[sel], 32'd0);
  endtask

  initial begin
    logic [31:0] v, v1, v2;
    int t1;
    resetn    = 1'b0;
    mem_valid = 2'b11;
    mem_instr = 1'b0;
    mem_addr  = 32'h0000_0010;
    mem_wdata = 32'hFFFF_FFFF;
    mem_wstrb = 4'hF;

    // reset state with a RAM write request pending
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_ready", 32'(mem_ready[s]), 32'd0);
      check("rst_rdata", mem_rdata[s], 32'd0);
      check("rst_gpio",  gpio_out[s], 32'd0);
      check("rst_err",   32'(bus_err[s]), 32'd0);
      check("rst_ram_en", 32'(ram_en[s]), 32'd0);
      check("rst_ram_we", 32'(ram_we[s]), 32'd0);
    end
    mem_valid = 2'b00;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // 1 wait state: write then read RAM word 4
    xfer(1, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b1, 32'd0, 1'b1, 3, v);
    xfer(1, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, 3, v);

    // 0 wait states: partial-lane write
    xfer(0, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF,    1'b0, 1'b1, 32'd0, 1'b1, 2, v);
    xfer(0, 32'h0000_0008, 32'h1122_3344, 4'b0101, 1'b0, 1'b1, 32'd0, 1'b1, 2, v);
    xfer(0, 32'h0000_0008, 32'h0,         4'h0,    1'b0, 1'b1, 32'hDE22_BE44, 1'b1, 2, v);

    // GPIO byte-lane write and read back
    xfer(1, 32'h1000_0000, 32'hA5A5_A5A5, 4'b1000, 1'b0, 1'b0, 32'd0, 1'b1, 1, v);
    check("gpio_out", gpio_out[1], 32'hA500_0000);
    xfer(1, 32'h1000_0000, 32'h0, 4'h0, 1'b0, 1'b0, 32'hA500_0000, 1'b1, 1, v);

    // counter: two reads accepted 10 cycles apart; writes ignored without error
    t1 = cyc;
    xfer(1, 32'h1000_0004, 32'h0, 4'h0, 1'b0, 1'b0, 32'd0, 1'b0, 1, v1);
    while (cyc < t1 + 10) @(negedge clk);
    xfer(1, 32'h1000_0004, 32'h0, 4'h0, 1'b0, 1'b0, 32'd0, 1'b0, 1, v2);
    check("cnt_delta", v2 - v1, 32'd10);
    xfer(1, 32'h1000_0004, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 32'd0, 1'b1, 1, v);
    check("cnt_wr_noerr", 32'(bus_err[1]), 32'd0);

    // counter wrap: 0xFFFF_FFFF is followed by 0, read in that cycle
    force g_dut[1].u_dut.cyc_cnt = 32'hFFFF_FFFF;
    #1;
    release g_dut[1].u_dut.cyc_cnt;
    @(negedge clk);
    xfer(1, 32'h1000_0004, 32'h0, 4'h0, 1'b0, 1'b0, 32'd0, 1'b1, 1, v);

    // decode errors: unmapped address, then a fetch from GPIO
    xfer(1, 32'h2000_0000, 32'h0, 4'h0, 1'b0, 1'b0, 32'd0, 1'b1, 1, v);
    check("err_set", 32'(bus_err[1]), 32'd1);
    xfer(1, 32'h1000_0000, 32'h0, 4'h0, 1'b1, 1'b0, 32'd0, 1'b1, 1, v);
    check("err_sticky", 32'(bus_err[1]), 32'd1);
    check("gpio_kept", gpio_out[1], 32'hA500_0000);

    // reset during WAIT of a RAM read
    mem_addr  = 32'h0000_0010;
    mem_wstrb = 4'h0;
    mem_instr = 1'b0;
    mem_valid[1] = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    mem_valid[1] = 1'b0;
    v = 32'd0;
    repeat (4) begin
      @(negedge clk);
      v = v | 32'(mem_ready[1]);
    end
    resetn = 1'b1;
    @(negedge clk);
    v = v | 32'(mem_ready[1]);
    check("rst_no_ready", v, 32'd0);
    check("rst_err_clr",  32'(bus_err[1]), 32'd0);
    check("rst_gpio_clr", gpio_out[1], 32'd0);
    xfer(1, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, 3, v);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
